// File: rtl/memory_arbiter.sv
// memory_arbiter: grants a single-port memory to an instruction-fetch port and
// a data port, one transaction at a time. Data normally wins. A starvation
// counter hands the memory to a waiting fetch after STARVE_LIMIT back-to-back
// data grants. Misaligned data accesses complete at once with an error flag
// and never reach the memory.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_ready_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ready_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              i_ready_q, i_ready_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    // A port's request is not eligible in the cycle its READY pulse is out,
    // because the requester is still dropping REQ during that cycle.
    logic i_elig, d_elig;
    assign i_elig = i_req_i & ~i_ready_q;
    assign d_elig = d_req_i & ~d_ready_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_MAX) return c;
        return c + 1'b1;
    endfunction

    // Next-state: arbitration in IDLE, completion tracking in the BUSY states.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ready_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    if (d_elig && !(i_elig && starve_q == CNT_MAX)) begin
                        // Data grant; only counts toward starvation if a fetch waits.
                        starve_d = i_elig ? sat_inc(starve_q) : '0;
                        if (d_addr_i[1:0] != 2'b00) begin
                            d_ready_d = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = '0;
                        end else begin
                            mem_req_d   = 1'b1;
                            mem_we_d    = d_we_i;
                            mem_addr_d  = d_addr_i;
                            mem_wdata_d = d_wdata_i;
                            state_d     = BUSY_D;
                        end
                    end else if (i_elig) begin
                        starve_d    = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr_i;
                        mem_wdata_d = '0;
                        state_d     = BUSY_I;
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            BUSY_I: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    i_ready_d = 1'b1;
                    i_rdata_d = mem_rdata_i;
                    state_d   = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    d_rdata_d = mem_we_q ? '0 : mem_rdata_i;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ready_q   <= i_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign i_ready_o   = i_ready_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_ready_o   = d_ready_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_err_o     = d_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter: a per-cycle vector table for the
// single-transaction scenarios, plus hand sequences for starvation and reset.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_ready_o(i_ready), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ready_o(d_ready), .d_rdata_o(d_rdata), .d_err_o(d_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        ack;
        logic [31:0] mrd;
        logic        x_mreq;
        logic        x_mwe;
        logic [31:0] x_maddr;
        logic [31:0] x_mwd;
        logic        x_ir;
        logic [31:0] x_ird;
        logic        x_dr;
        logic [31:0] x_drd;
        logic        x_derr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // en ir ia dr dwe da dwd ack mrd | mreq mwe maddr mwd ir ird dr drd derr
    task automatic add(input logic en, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic ack, input logic [31:0] mrd,
                       input logic x_mreq, input logic x_mwe, input logic [31:0] x_maddr,
                       input logic [31:0] x_mwd, input logic x_ir, input logic [31:0] x_ird,
                       input logic x_dr, input logic [31:0] x_drd, input logic x_derr);
        vec_t v;
        v.en = en; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da;
        v.dwd = dwd; v.ack = ack; v.mrd = mrd; v.x_mreq = x_mreq; v.x_mwe = x_mwe;
        v.x_maddr = x_maddr; v.x_mwd = x_mwd; v.x_ir = x_ir; v.x_ird = x_ird;
        v.x_dr = x_dr; v.x_drd = x_drd; v.x_derr = x_derr;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        enable = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Four data grants while a fetch waits, then the fetch must win.
    // ENABLE is dropped in each D_READY cycle so the fetch cannot be granted
    // through the READY-cycle exception and the data grants stay consecutive.
    task automatic starve_round(input int r);
        i_req = 1'b1; i_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            enable = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400 + 32'(4 * k);
            tick();
            chk($sformatf("starve%0d_dgrant%0d_req", r, k), {31'b0, mem_req}, 32'd1);
            chk($sformatf("starve%0d_dgrant%0d_addr", r, k), mem_addr, 32'h400 + 32'(4 * k));
            mem_ack = 1'b1; mem_rdata = 32'h70 + 32'(k);
            tick();
            mem_ack = 1'b0;
            chk($sformatf("starve%0d_dready%0d", r, k), {31'b0, d_ready}, 32'd1);
            chk($sformatf("starve%0d_drdata%0d", r, k), d_rdata, 32'h70 + 32'(k));
            enable = 1'b0; d_req = 1'b0;
            tick();
            chk($sformatf("starve%0d_gap%0d_req", r, k), {31'b0, mem_req}, 32'd0);
        end
        enable = 1'b1; d_req = 1'b1; d_addr = 32'h410;
        tick();
        chk($sformatf("starve%0d_fetch_req", r), {31'b0, mem_req}, 32'd1);
        chk($sformatf("starve%0d_fetch_addr", r), mem_addr, 32'h300);
        chk($sformatf("starve%0d_fetch_we", r), {31'b0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h3000 + 32'(r);
        tick();
        mem_ack = 1'b0;
        chk($sformatf("starve%0d_iready", r), {31'b0, i_ready}, 32'd1);
        chk($sformatf("starve%0d_irdata", r), i_rdata, 32'h3000 + 32'(r));
        chk($sformatf("starve%0d_no_dready", r), {31'b0, d_ready}, 32'd0);
        enable = 1'b0; i_req = 1'b0; d_req = 1'b0;
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        // Lone fetch, ack two cycles after MEM_REQ rises, then ack while idle.
        add(1,1,32'h40,0,0,0,0,0,0,                   1,0,32'h40,0,0,0,0,0,0);
        add(1,1,32'h40,0,0,0,0,0,0,                   1,0,32'h40,0,0,0,0,0,0);
        add(1,1,32'h40,0,0,0,0,0,0,                   1,0,32'h40,0,0,0,0,0,0);
        add(1,1,32'h40,0,0,0,0,1,32'h2402000A,        0,0,0,0,1,32'h2402000A,0,0,0);
        add(1,0,0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,1,32'hDEAD0000,             0,0,0,0,0,0,0,0,0);
        // Simultaneous fetch and store: store first, fetch in the D_READY cycle.
        add(1,1,32'h80,1,1,32'h100,32'hDEADBEEF,0,0,  1,1,32'h100,32'hDEADBEEF,0,0,0,0,0);
        add(1,1,32'h80,1,1,32'h100,32'hDEADBEEF,1,32'h12345678, 0,0,0,0,0,0,1,0,0);
        add(1,1,32'h80,0,0,0,0,0,0,                   1,0,32'h80,0,0,0,0,0,0);
        add(1,1,32'h80,0,0,0,0,1,32'hCAFEF00D,        0,0,0,0,1,32'hCAFEF00D,0,0,0);
        add(1,0,0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,0);
        // Aligned load, then misaligned load that must not touch memory.
        add(1,0,0,1,0,32'h200,0,0,0,                  1,0,32'h200,0,0,0,0,0,0);
        add(1,0,0,1,0,32'h200,0,1,32'h55AA55AA,       0,0,0,0,0,0,1,32'h55AA55AA,0);
        add(1,0,0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,0);
        add(1,0,0,1,0,32'h103,0,0,0,                  0,0,0,0,0,0,1,0,1);
        add(1,0,0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,0);
        // ENABLE low holds off a fetch; raising it grants on the next edge.
        add(0,1,32'h44,0,0,0,0,0,0,                   0,0,0,0,0,0,0,0,0);
        add(0,1,32'h44,0,0,0,0,0,0,                   0,0,0,0,0,0,0,0,0);
        add(1,1,32'h44,0,0,0,0,0,0,                   1,0,32'h44,0,0,0,0,0,0);
        add(1,1,32'h44,0,0,0,0,1,32'h0BADCAFE,        0,0,0,0,1,32'h0BADCAFE,0,0,0);
        add(1,0,0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,0);

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_i_ready", {31'b0, i_ready}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_ready", {31'b0, d_ready}, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_d_err", {31'b0, d_err}, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[n]) begin
            enable = vecs[n].en; i_req = vecs[n].ir; i_addr = vecs[n].ia;
            d_req = vecs[n].dr; d_we = vecs[n].dwe; d_addr = vecs[n].da;
            d_wdata = vecs[n].dwd; mem_ack = vecs[n].ack; mem_rdata = vecs[n].mrd;
            tick();
            chk($sformatf("v%0d_mem_req", n), {31'b0, mem_req}, {31'b0, vecs[n].x_mreq});
            if (vecs[n].x_mreq) begin
                chk($sformatf("v%0d_mem_we", n), {31'b0, mem_we}, {31'b0, vecs[n].x_mwe});
                chk($sformatf("v%0d_mem_addr", n), mem_addr, vecs[n].x_maddr);
                if (vecs[n].x_mwe)
                    chk($sformatf("v%0d_mem_wdata", n), mem_wdata, vecs[n].x_mwd);
            end
            chk($sformatf("v%0d_i_ready", n), {31'b0, i_ready}, {31'b0, vecs[n].x_ir});
            if (vecs[n].x_ir)
                chk($sformatf("v%0d_i_rdata", n), i_rdata, vecs[n].x_ird);
            chk($sformatf("v%0d_d_ready", n), {31'b0, d_ready}, {31'b0, vecs[n].x_dr});
            if (vecs[n].x_dr)
                chk($sformatf("v%0d_d_rdata", n), d_rdata, vecs[n].x_drd);
            chk($sformatf("v%0d_d_err", n), {31'b0, d_err}, {31'b0, vecs[n].x_derr});
            chk($sformatf("v%0d_ready_overlap", n), {31'b0, i_ready & d_ready}, 32'd0);
        end

        // Two rounds: the second only yields four data grants before the fetch
        // if the counter went back to zero on the first round's fetch grant.
        idle_inputs();
        tick();
        starve_round(1);
        starve_round(2);

        // Reset in BUSY_D before the ack; the late ack must be ignored.
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h11;
        tick();
        chk("rstmid_grant_req", {31'b0, mem_req}, 32'd1);
        chk("rstmid_grant_we", {31'b0, mem_we}, 32'd1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_async_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstmid_async_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rstmid_async_mem_addr", mem_addr, 32'd0);
        tick();
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b1; mem_rdata = 32'h99;
        tick();
        mem_ack = 1'b0;
        chk("rstmid_late_ack_d_ready", {31'b0, d_ready}, 32'd0);
        chk("rstmid_late_ack_i_ready", {31'b0, i_ready}, 32'd0);
        chk("rstmid_late_ack_mem_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("rstmid_after_d_ready", {31'b0, d_ready}, 32'd0);
        i_req = 1'b1; i_addr = 32'h600;
        tick();
        chk("rstmid_idle_grant_req", {31'b0, mem_req}, 32'd1);
        chk("rstmid_idle_grant_addr", mem_addr, 32'h600);
        mem_ack = 1'b1; mem_rdata = 32'h600D;
        tick();
        mem_ack = 1'b0;
        chk("rstmid_fetch_ready", {31'b0, i_ready}, 32'd1);
        chk("rstmid_fetch_rdata", i_rdata, 32'h600D);
        i_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
